// File: rtl/ifid_hazard_stage_if.sv
// ifid_hazard_stage_if
//   Bundles the fetch-side inputs, ID/EX hazard inputs and the registered
//   and combinational outputs of the IF/ID stage.
//   master : environment side (drives fetch/hazard inputs, observes outputs)
//   slave  : the IF/ID stage itself
//   Signals:
//     instruction_in / adder1_in    fetched instruction and PC+4
//     idex_mem_read / idex_rt       load indication and Rt held in ID/EX
//     branch_taken / jump           redirect requests resolved in ID
//     instruction_out / adder1_out  registered instruction and PC+4 to ID
//     valid_out                     instruction_out is a real instruction
//     pc_write / ctrl_bubble        PC enable, ID/EX control zeroing select
//     stall_count / flush_count     saturating debug counters
interface ifid_hazard_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] instruction_in;
  logic [DATA_W-1:0] adder1_in;
  logic              idex_mem_read;
  logic [4:0]        idex_rt;
  logic              branch_taken;
  logic              jump;
  logic [DATA_W-1:0] instruction_out;
  logic [DATA_W-1:0] adder1_out;
  logic              valid_out;
  logic              pc_write;
  logic              ctrl_bubble;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output instruction_in, adder1_in, idex_mem_read, idex_rt, branch_taken, jump,
    input  instruction_out, adder1_out, valid_out, pc_write, ctrl_bubble,
           stall_count, flush_count
  );

  modport slave (
    input  instruction_in, adder1_in, idex_mem_read, idex_rt, branch_taken, jump,
    output instruction_out, adder1_out, valid_out, pc_write, ctrl_bubble,
           stall_count, flush_count
  );
endinterface

// File: rtl/ifid_hazard_stage.sv
// ifid_hazard_stage
//   IF/ID pipeline register of a 5-stage MIPS pipeline with load-use hazard
//   detection folded in.
//   Ports:
//     clock  rising-edge clock
//     reset  asynchronous active-low reset (0 = reset)
//     bus    ifid_hazard_stage_if.slave (fetch inputs, hazard inputs,
//            registered instruction/PC+4, pc_write, ctrl_bubble, counters)
//   Stall/flush protocol: there is no valid/ready handshake on this stage.
//   pc_write low means fetch must hold its PC for this cycle, and this
//   register holds too; ctrl_bubble high means ID/EX must capture zeroed
//   control. A flush replaces the held instruction with NOP_WORD.
module ifid_hazard_stage #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000,
  parameter int                CNT_W    = 16
) (
  input logic clock,
  input logic reset,
  ifid_hazard_stage_if.slave bus
);

  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] add_q, add_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic       hazard;
  logic       flush_req;

  assign rs_id = instr_q[25:21];
  assign rt_id = instr_q[20:16];

  // Matching rt_id as well as rs_id is deliberately conservative: I-type
  // instructions whose rt is a destination may stall needlessly.
  assign hazard = valid_q & bus.idex_mem_read & (bus.idex_rt != 5'd0) &
                  ((rs_id == bus.idex_rt) | (rt_id == bus.idex_rt));

  // A redirect whose operands are still waiting on a load is deferred until
  // the stall cycle has passed.
  assign flush_req = (bus.branch_taken | bus.jump) & ~hazard;

  always_comb begin
    instr_d = instr_q;
    add_d   = add_q;
    valid_d = valid_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if (flush_req) begin
      instr_d = NOP_WORD;
      add_d   = '0;
      valid_d = 1'b0;
      if (flush_q != {CNT_W{1'b1}}) flush_d = flush_q + 1'b1;
    end else if (hazard) begin
      if (stall_q != {CNT_W{1'b1}}) stall_d = stall_q + 1'b1;
    end else begin
      instr_d = bus.instruction_in;
      add_d   = bus.adder1_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_q <= NOP_WORD;
      add_q   <= '0;
      valid_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      instr_q <= instr_d;
      add_q   <= add_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.instruction_out = instr_q;
  assign bus.adder1_out      = add_q;
  assign bus.valid_out       = valid_q;
  assign bus.pc_write        = ~hazard;
  assign bus.ctrl_bubble     = hazard | ~valid_q;
  assign bus.stall_count     = stall_q;
  assign bus.flush_count     = flush_q;

endmodule
